rf_wr_sched: RTL and testbench
==============================

# rf_wr_sched

Register-file write scheduler and long-latency scoreboard. Shares the register file's single write port between the in-order pipeline WB stage and a multi-cycle (mul/div) writeback unit, and stalls issue on register hazards against outstanding long-latency results. Sits between the WB stage / long unit and the register file write port (`we`, `dst_reg_WB`, `dst_reg_data_WB`), and drives the issue-stage stall.

## Interface
- `LONG_MAX`, 4: maximum outstanding long-latency ops.
- `STARVE_MAX`, 8: consecutive denied cycles before the long unit forces an issue stall.

- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `issue_vld`  in  1  instruction present at issue.
- `issue_long`  in  1  instruction goes to the long unit.
- `issue_we`  in  1  instruction writes a register.
- `issue_dst`  in  5  destination register.
- `issue_regS`, `issue_regT`  in  5 each  source registers.
- `issue_reS`, `issue_reT`  in  1 each  source used.
- `stall`  out  1  hold issue this cycle (combinational).
- `pipe_wb_vld`  in  1  pipeline WB write request (cannot be stalled).
- `pipe_wb_dst`  in  5; `pipe_wb_data`  in  32.
- `long_wb_vld`  in  1  long unit result valid; held until accepted.
- `long_wb_dst`  in  5; `long_wb_data`  in  32.
- `long_wb_rdy`  out  1  long result accepted this cycle (combinational).
- `rf_we`  out  1  to RF `we`.
- `rf_dst`  out  5  to RF `dst_reg_WB`.
- `rf_data`  out  32  to RF `dst_reg_data_WB`.
- `pending`  out  32  scoreboard vector (debug).

## Operation
- Grant: `pipe_wb_vld` always wins. `long_wb_rdy = long_wb_vld & ~pipe_wb_vld`. Exactly one source granted per cycle or none.
- Scoreboard: `pending[r]` set when a long op issues (`issue_vld & ~stall & issue_long & issue_we & issue_dst!=0`); cleared when long writeback to r is granted. Bit 0 never set. Short ops never set pending (forwarding handled elsewhere).
- Outstanding count `cnt` (width clog2(LONG_MAX+1)): +1 on long issue, −1 on long grant, unchanged if both.
- `stall = issue_vld & (hazS | hazT | waw | full | starve)`:
  - hazS: `issue_reS & pending[issue_regS]`; hazT likewise for regT.
  - waw: `issue_we & pending[issue_dst]`.
  - full: `issue_long & cnt==LONG_MAX`.
  - starve: starvation counter == STARVE_MAX.
- Starvation counter: increments each cycle `long_wb_vld & ~long_wb_rdy`, saturates at STARVE_MAX, clears on long grant or `~long_wb_vld`. While saturated, issue stalls so bubbles reach WB.
- Write to r0 from either source: grant consumes it, `rf_we` stays 0.
- Long grant to a register with pending=0: protocol error; still written, pending unchanged, `cnt` still decremented (saturate at 0).

## Timing
- Reset: `rf_we`=0, `rf_dst`=0, `rf_data`=0, `pending`=0, `cnt`=0, starve counter=0. `stall`, `long_wb_rdy` follow inputs combinationally from reset state.
- Write path latency 1: grant in cycle N → `rf_we/rf_dst/rf_data` registered, valid cycle N+1 (RF writes while clk high of N+1).
- Scoreboard updates at posedge; a clear in cycle N removes the stall from cycle N+1. Dependent consumer of a long result issues no earlier than 1 cycle after grant (RF value visible by then).
- Same-register set and clear in one cycle cannot occur (waw stall); if forced, set wins.
- Reset mid-operation: all state cleared immediately; in-flight long results lost (long unit is reset by the same `rst_n`).

## Structure
- `rf_pkg`: `NUM_REGS`=32, `REG_AW`=5, `DATA_W`=32, `wb_src_e` {WB_NONE, WB_PIPE, WB_LONG}.
- Sub-module `rf_scoreboard`: pending vector, outstanding count, hazard/full terms. `rf_wr_sched` holds grant logic, starvation counter and output registers.

## Test plan
- Reset: assert `rst_n`=0 mid-traffic → all outputs/pending 0 next edge-free, `long_wb_rdy` = `long_wb_vld`.
- Long issue dst=5, then short issue reading r5 → `stall`=1 until long grant of r5 (data 0xDEADBEEF); stall drops cycle after; `rf_we`=1, `rf_dst`=5, `rf_data`=0xDEADBEEF one cycle after grant.
- Simultaneous `pipe_wb_vld` (r3, 0x11) and `long_wb_vld` (r7, 0x22) → cycle N+1 writes r3, `long_wb_rdy`=0; next free cycle writes r7.
- Issue 4 long ops (r1..r4), 5th long op → `stall`=1 (full); one grant releases it next cycle; short non-dependent op issues meanwhile.
- `pipe_wb_vld` held high 9 cycles with long pending → `stall`=1 from 9th denied cycle on; first pipe bubble grants long, stall clears.
- Long writeback to r0 → `long_wb_rdy`=1, `rf_we`=0, `cnt` decrements; r0 never appears in `pending`.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths and write-source encoding
package rf_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {WB_NONE, WB_PIPE, WB_LONG} wb_src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-result vector, outstanding long-op count and issue hazard terms
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int LONG_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_go,
  input  logic                issue_long,
  input  logic                issue_we,
  input  logic [REG_AW-1:0]   issue_dst,
  input  logic [REG_AW-1:0]   issue_regS,
  input  logic [REG_AW-1:0]   issue_regT,
  input  logic                issue_reS,
  input  logic                issue_reT,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_dst,
  output logic                haz,
  output logic [NUM_REGS-1:0] pending
);
  localparam int CW = $clog2(LONG_MAX + 1);
  logic [CW-1:0] cnt;
  logic inc;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  always_comb begin
    inc = issue_go & issue_long & issue_we;
    set_mask = inc && issue_dst != '0 ? NUM_REGS'(1) << issue_dst : '0;
    clr_mask = clr_en ? NUM_REGS'(1) << clr_dst : '0;
    haz = (issue_reS & pending[issue_regS]) | (issue_reT & pending[issue_regT]) |
          (issue_we & pending[issue_dst]) | (issue_long & cnt == CW'(LONG_MAX));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      cnt <= inc & ~clr_en ? cnt + CW'(1) : ~inc & clr_en & cnt != '0 ? cnt - CW'(1) : cnt;
    end
endmodule

// File: rtl/rf_wr_sched.sv
// rf_wr_sched: shares the RF write port between WB and the long unit and stalls issue on hazards
module rf_wr_sched
  import rf_pkg::*;
#(
  parameter int LONG_MAX = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_vld,
  input  logic                issue_long,
  input  logic                issue_we,
  input  logic [REG_AW-1:0]   issue_dst,
  input  logic [REG_AW-1:0]   issue_regS,
  input  logic [REG_AW-1:0]   issue_regT,
  input  logic                issue_reS,
  input  logic                issue_reT,
  output logic                stall,
  input  logic                pipe_wb_vld,
  input  logic [REG_AW-1:0]   pipe_wb_dst,
  input  logic [DATA_W-1:0]   pipe_wb_data,
  input  logic                long_wb_vld,
  input  logic [REG_AW-1:0]   long_wb_dst,
  input  logic [DATA_W-1:0]   long_wb_data,
  output logic                long_wb_rdy,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_dst,
  output logic [DATA_W-1:0]   rf_data,
  output logic [NUM_REGS-1:0] pending
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic haz, starve;
  wb_src_e src;
  logic [REG_AW-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  always_comb begin
    long_wb_rdy = long_wb_vld & ~pipe_wb_vld;
    src = pipe_wb_vld ? WB_PIPE : long_wb_vld ? WB_LONG : WB_NONE;
    wb_dst = pipe_wb_vld ? pipe_wb_dst : long_wb_dst;
    wb_data = pipe_wb_vld ? pipe_wb_data : long_wb_data;
    starve = starve_cnt == SW'(STARVE_MAX);
    stall = issue_vld & (haz | starve);
  end
  rf_scoreboard #(.LONG_MAX(LONG_MAX)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_go   (issue_vld & ~stall),
    .issue_long (issue_long),
    .issue_we   (issue_we),
    .issue_dst  (issue_dst),
    .issue_regS (issue_regS),
    .issue_regT (issue_regT),
    .issue_reS  (issue_reS),
    .issue_reT  (issue_reT),
    .clr_en     (long_wb_rdy),
    .clr_dst    (long_wb_dst),
    .haz        (haz),
    .pending    (pending)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_cnt <= '0;
      rf_we <= 1'b0;
      rf_dst <= '0;
      rf_data <= '0;
    end else begin
      starve_cnt <= ~long_wb_vld | long_wb_rdy ? '0 : starve ? starve_cnt : starve_cnt + SW'(1);
      rf_we <= src != WB_NONE && wb_dst != '0;
      if (src != WB_NONE) begin
        rf_dst <= wb_dst;
        rf_data <= wb_data;
      end
    end
endmodule

// File: tb/tb_rf_wr_sched.sv
// tb_rf_wr_sched: directed and random stimulus checked against a scoreboard-level reference model
module tb_rf_wr_sched;
  logic clk = 0, rst_n = 0;
  logic issue_vld = 0, issue_long = 0, issue_we = 0, issue_reS = 0, issue_reT = 0;
  logic [4:0] issue_dst = 0, issue_regS = 0, issue_regT = 0;
  logic pipe_wb_vld = 0, long_wb_vld = 0;
  logic [4:0] pipe_wb_dst = 0, long_wb_dst = 0;
  logic [31:0] pipe_wb_data = 0, long_wb_data = 0;
  logic stall, long_wb_rdy, rf_we;
  logic [4:0] rf_dst;
  logic [31:0] rf_data, pending;
  int errs = 0, checks = 0;
  bit [31:0] m_pend;
  int m_cnt, m_st;
  bit m_we;
  bit [4:0] m_dst;
  bit [31:0] m_data;
  bit e_stall, e_rdy;
  bit [4:0] q[$];

  rf_wr_sched dut (
    .clk(clk), .rst_n(rst_n), .issue_vld(issue_vld), .issue_long(issue_long), .issue_we(issue_we),
    .issue_dst(issue_dst), .issue_regS(issue_regS), .issue_regT(issue_regT), .issue_reS(issue_reS),
    .issue_reT(issue_reT), .stall(stall), .pipe_wb_vld(pipe_wb_vld), .pipe_wb_dst(pipe_wb_dst),
    .pipe_wb_data(pipe_wb_data), .long_wb_vld(long_wb_vld), .long_wb_dst(long_wb_dst),
    .long_wb_data(long_wb_data), .long_wb_rdy(long_wb_rdy), .rf_we(rf_we), .rf_dst(rf_dst),
    .rf_data(rf_data), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    bit go;
    #1;
    e_stall = issue_vld && ((issue_reS && m_pend[issue_regS]) || (issue_reT && m_pend[issue_regT]) ||
              (issue_we && m_pend[issue_dst]) || (issue_long && m_cnt == 4) || m_st == 8);
    e_rdy = long_wb_vld && !pipe_wb_vld;
    chk("stall", stall, e_stall);
    chk("long_rdy", long_wb_rdy, e_rdy);
    @(posedge clk);
    go = issue_vld && !e_stall && issue_long && issue_we;
    if (pipe_wb_vld) begin
      m_we = pipe_wb_dst != 0; m_dst = pipe_wb_dst; m_data = pipe_wb_data;
    end else if (long_wb_vld) begin
      m_we = long_wb_dst != 0; m_dst = long_wb_dst; m_data = long_wb_data;
    end else m_we = 0;
    if (e_rdy) m_pend[long_wb_dst] = 0;
    if (go && issue_dst != 0) m_pend[issue_dst] = 1;
    m_cnt = m_cnt + int'(go) - int'(e_rdy);
    if (m_cnt < 0) m_cnt = 0;
    m_st = (!long_wb_vld || e_rdy) ? 0 : (m_st < 8 ? m_st + 1 : 8);
    if (go) q.push_back(issue_dst);
    @(negedge clk);
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_dst", rf_dst, m_dst);
      chk("rf_data", rf_data, m_data);
    end
    chk("pending", pending, m_pend);
  endtask

  task automatic idle();
    issue_vld = 0; issue_long = 0; issue_we = 0; issue_reS = 0; issue_reT = 0;
    pipe_wb_vld = 0; long_wb_vld = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_dst", rf_dst, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_rdy", long_wb_rdy, long_wb_vld);
    m_pend = 0; m_cnt = 0; m_st = 0; m_we = 0; q.delete();
    idle();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic issue(input bit lng, input bit [4:0] dst, input bit [4:0] rs, input bit res);
    issue_vld = 1; issue_long = lng; issue_we = 1; issue_dst = dst;
    issue_regS = rs; issue_reS = res; issue_reT = 0;
  endtask

  initial begin
    @(negedge clk);
    long_wb_vld = 1; pipe_wb_vld = 0; issue_vld = 1;
    do_reset();
    // dependent issue waits for long result
    issue(1, 5, 0, 0); cyc();
    issue(0, 6, 5, 1); cyc(); cyc();
    chk("dep_stall", stall, 1);
    long_wb_vld = 1; long_wb_dst = 5; long_wb_data = 32'hDEADBEEF; cyc();
    long_wb_vld = 0;
    chk("dep_we", rf_we, 1);
    chk("dep_dst", rf_dst, 5);
    chk("dep_data", rf_data, 32'hDEADBEEF);
    #1 chk("dep_release", stall, 0);
    cyc(); idle(); cyc();
    // pipe beats long
    pipe_wb_vld = 1; pipe_wb_dst = 3; pipe_wb_data = 32'h11;
    long_wb_vld = 1; long_wb_dst = 7; long_wb_data = 32'h22; cyc();
    chk("arb_dst_pipe", rf_dst, 3);
    chk("arb_data_pipe", rf_data, 32'h11);
    pipe_wb_vld = 0; cyc(); long_wb_vld = 0;
    chk("arb_dst_long", rf_dst, 7);
    chk("arb_data_long", rf_data, 32'h22);
    // full
    do_reset();
    for (int i = 1; i <= 4; i++) begin issue(1, 5'(i), 0, 0); cyc(); end
    issue(1, 8, 0, 0); cyc();
    chk("full_stall", stall, 1);
    long_wb_vld = 1; long_wb_dst = 1; cyc(); long_wb_vld = 0;
    #1 chk("full_release", stall, 0);
    issue(0, 9, 2, 0); cyc(); cyc();
    // starvation
    do_reset();
    issue(1, 9, 0, 0); cyc();
    issue(0, 10, 1, 1); pipe_wb_vld = 1; pipe_wb_dst = 11; long_wb_vld = 1; long_wb_dst = 9;
    for (int i = 0; i < 9; i++) cyc();
    chk("starve_stall", stall, 1);
    pipe_wb_vld = 0; cyc(); cyc();
    chk("starve_clear", stall, 0);
    // long write to r0
    do_reset();
    issue(1, 0, 0, 0); cyc(); idle();
    long_wb_vld = 1; long_wb_dst = 0; long_wb_data = 32'h55; cyc(); long_wb_vld = 0;
    chk("r0_we", rf_we, 0);
    for (int i = 1; i <= 4; i++) begin issue(1, 5'(i), 0, 0); cyc(); end
    idle(); cyc();
    // random traffic with a FIFO long unit
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      issue_vld = $urandom % 4 != 0; issue_long = $urandom % 3 == 0; issue_we = $urandom % 4 != 0;
      issue_dst = 5'($urandom % 8); issue_regS = 5'($urandom % 8); issue_regT = 5'($urandom % 8);
      issue_reS = 1'($urandom); issue_reT = 1'($urandom);
      pipe_wb_vld = $urandom % 3 == 0; pipe_wb_dst = 5'($urandom); pipe_wb_data = $urandom;
      if (n % 200 == 150) pipe_wb_vld = 1;
      cyc();
      if (e_rdy) long_wb_vld = 0;
      if (!long_wb_vld && q.size() > 0 && $urandom % 2 == 1) begin
        long_wb_vld = 1; long_wb_dst = q.pop_front(); long_wb_data = $urandom;
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
